// File: rtl/approx_sweep_pkg.sv
// Shared types and helpers for the approximate-adder error sweeper.
// Holds the FSM encoding, drain length and the abs-difference helper.
package approx_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    localparam int DRAIN_CYCLES = 2;
    localparam int DIFF_W = 32;

    function automatic logic [DIFF_W-1:0] abs_diff(
        input logic [DIFF_W-1:0] x,
        input logic [DIFF_W-1:0] y
    );
        return (x > y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/approx_err_accum.sv
// Stage 2: compares one sampled adder output with the exact sum and
// folds the absolute error into the running max/count/sum/violation.
module approx_err_accum
    import approx_sweep_pkg::*;
#(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 3,
    parameter int ET       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        valid,
    input  logic [IN_BITS/2-1:0]        a,
    input  logic [IN_BITS/2-1:0]        b,
    input  logic [OUT_BITS-1:0]         approx,
    output logic [OUT_BITS-1:0]         max_err,
    output logic [IN_BITS:0]            err_count,
    output logic [IN_BITS+OUT_BITS-1:0] err_sum,
    output logic                        violation
);

    localparam int SUM_W = IN_BITS + OUT_BITS;

    logic [OUT_BITS-1:0] exact;
    logic [OUT_BITS-1:0] err;
    logic                over_et;

    assign exact   = OUT_BITS'(a) + OUT_BITS'(b);
    assign err     = OUT_BITS'(abs_diff(DIFF_W'(exact), DIFF_W'(approx)));
    assign over_et = DIFF_W'(err) > DIFF_W'(ET);

    // Accumulators: cleared by an accepted start, updated per valid sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_err   <= '0;
            err_count <= '0;
            err_sum   <= '0;
            violation <= 1'b0;
        end else if (clear) begin
            max_err   <= '0;
            err_count <= '0;
            err_sum   <= '0;
            violation <= 1'b0;
        end else if (valid) begin
            if (err > max_err) begin
                max_err <= err;
            end
            if (err != '0) begin
                err_count <= err_count + (IN_BITS+1)'(1);
            end
            err_sum   <= err_sum + SUM_W'(err);
            violation <= violation | over_et;
        end
    end

endmodule

// File: rtl/approx_error_sweeper.sv
// Drives every input vector into an approximate adder, samples its output
// and accumulates error statistics against the exact sum.
module approx_error_sweeper
    import approx_sweep_pkg::*;
#(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 3,
    parameter int ET       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [IN_BITS-1:0]          approx_in,
    input  logic [OUT_BITS-1:0]         approx_out,
    output logic [OUT_BITS-1:0]         max_err,
    output logic [IN_BITS:0]            err_count,
    output logic [IN_BITS+OUT_BITS-1:0] err_sum,
    output logic                        violation
);

    localparam int HALF = IN_BITS / 2;
    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [IN_BITS-1:0] VEC_LAST = '1;
    localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);

    state_t state, state_nxt;

    logic [IN_BITS-1:0]  vec;
    logic [DC_W-1:0]     drain_cnt;
    logic                clear;
    logic                s1_valid;
    logic [HALF-1:0]     s1_a;
    logic [HALF-1:0]     s1_b;
    logic [OUT_BITS-1:0] s1_out;

    assign approx_in = vec;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (vec == VEC_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector counter and drain timer; vec holds after the last vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            drain_cnt <= '0;
        end else begin
            if (clear) begin
                vec <= '0;
            end else if (state == SWEEP && vec != VEC_LAST) begin
                vec <= vec + IN_BITS'(1);
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + DC_W'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // Stage 1: capture operands and adder output of the driven vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_out   <= '0;
        end else begin
            s1_valid <= (state == SWEEP) && !clear;
            if (state == SWEEP) begin
                s1_a   <= vec[HALF-1:0];
                s1_b   <= vec[IN_BITS-1:HALF];
                s1_out <= approx_out;
            end
        end
    end

    approx_err_accum #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .ET       (ET)
    ) u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .valid     (s1_valid),
        .a         (s1_a),
        .b         (s1_b),
        .approx    (s1_out),
        .max_err   (max_err),
        .err_count (err_count),
        .err_sum   (err_sum),
        .violation (violation)
    );

endmodule

// File: tb/tb_approx_error_sweeper.sv
// Bench: three sweepers (ET = 0, 1, 7) share start and an adder table;
// results are checked against error statistics computed from the table.
module tb_approx_error_sweeper;

    localparam int IB = 4;
    localparam int OB = 3;
    localparam int N  = 16;
    localparam int ETS [3] = '{0, 1, 7};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    logic [IB-1:0]    ain  [3];
    logic [OB-1:0]    aout [3];
    logic             busy [3];
    logic             done [3];
    logic             viol [3];
    logic [OB-1:0]    merr [3];
    logic [IB:0]      ecnt [3];
    logic [IB+OB-1:0] esum [3];

    logic [OB-1:0] tbl [N];

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_adder
        assign aout[i] = tbl[ain[i]];
    end

    approx_error_sweeper #(.IN_BITS(IB), .OUT_BITS(OB), .ET(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]),
        .done(done[0]), .approx_in(ain[0]), .approx_out(aout[0]),
        .max_err(merr[0]), .err_count(ecnt[0]), .err_sum(esum[0]),
        .violation(viol[0])
    );

    approx_error_sweeper #(.IN_BITS(IB), .OUT_BITS(OB), .ET(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[1]),
        .done(done[1]), .approx_in(ain[1]), .approx_out(aout[1]),
        .max_err(merr[1]), .err_count(ecnt[1]), .err_sum(esum[1]),
        .violation(viol[1])
    );

    approx_error_sweeper #(.IN_BITS(IB), .OUT_BITS(OB), .ET(7)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[2]),
        .done(done[2]), .approx_in(ain[2]), .approx_out(aout[2]),
        .max_err(merr[2]), .err_count(ecnt[2]), .err_sum(esum[2]),
        .violation(viol[2])
    );

    always @(negedge clk) begin
        if (done[0]) pulses++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int mode);
        for (int i = 0; i < N; i++) begin
            int a, b;
            a = i % 4;
            b = i / 4;
            case (mode)
                0: tbl[i] = OB'(a + b);
                1: tbl[i] = 3'd0;
                2: tbl[i] = 3'd7;
                3: tbl[i] = (a == 3 && b == 1) ? 3'd5 : OB'(a + b);
                default: tbl[i] = OB'($urandom_range(0, 7));
            endcase
        end
    endtask

    task automatic check_results(input string tag);
        int mx, cn, sm;
        mx = 0; cn = 0; sm = 0;
        for (int i = 0; i < N; i++) begin
            int e, d;
            e = (i % 4) + (i / 4);
            d = (e > int'(tbl[i])) ? e - int'(tbl[i]) : int'(tbl[i]) - e;
            if (d > mx) mx = d;
            if (d != 0) cn++;
            sm += d;
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_max_et%0d", tag, ETS[k]), merr[k], mx);
            chk($sformatf("%s_cnt_et%0d", tag, ETS[k]), ecnt[k], cn);
            chk($sformatf("%s_sum_et%0d", tag, ETS[k]), esum[k], sm);
            chk($sformatf("%s_viol_et%0d", tag, ETS[k]), viol[k],
                (mx > ETS[k]) ? 1 : 0);
        end
    endtask

    task automatic run_sweep(input int mode, input bit poke, input string tag);
        int cnt, p0;
        load(mode);
        p0 = pulses;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 1;
        chk({tag, "_busy"}, busy[0], 1);
        while (!done[0] && cnt < 40) begin
            if (poke && cnt == 5) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cnt++;
            if (cnt == 6) chk({tag, "_vec5"}, ain[0], 5);
        end
        chk({tag, "_latency"}, cnt, 19);
        check_results(tag);
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_low"}, done[0], 0);
        chk({tag, "_idle"}, busy[0], 0);
        chk({tag, "_one_pulse"}, pulses - p0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_still_idle"}, busy[0], 0);
        check_results({tag, "_hold"});
    endtask

    initial begin
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy%0d", k), busy[k], 0);
            chk($sformatf("rst_done%0d", k), done[k], 0);
            chk($sformatf("rst_ain%0d", k), ain[k], 0);
            chk($sformatf("rst_max%0d", k), merr[k], 0);
            chk($sformatf("rst_cnt%0d", k), ecnt[k], 0);
            chk($sformatf("rst_sum%0d", k), esum[k], 0);
            chk($sformatf("rst_viol%0d", k), viol[k], 0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_sweep(0, 1'b0, "exact");
        run_sweep(1, 1'b1, "stuck0");
        run_sweep(2, 1'b0, "stuck7");
        run_sweep(3, 1'b0, "onewrong");

        begin
            int p0;
            load(1);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (7) @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("abort_busy%0d", k), busy[k], 0);
                chk($sformatf("abort_done%0d", k), done[k], 0);
                chk($sformatf("abort_ain%0d", k), ain[k], 0);
                chk($sformatf("abort_max%0d", k), merr[k], 0);
                chk($sformatf("abort_cnt%0d", k), ecnt[k], 0);
                chk($sformatf("abort_sum%0d", k), esum[k], 0);
                chk($sformatf("abort_viol%0d", k), viol[k], 0);
            end
            p0 = pulses;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (25) @(posedge clk);
            #1;
            chk("abort_no_done", pulses - p0, 0);
            chk("abort_idle", busy[0], 0);
        end

        run_sweep(1, 1'b0, "after_abort");

        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            run_sweep(4, r[0], $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
